// File: rtl/uart_reg_cmd.sv
// uart_reg_cmd
// Byte-stream command decoder that sits directly behind the UART receiver.
// It assembles framed register-write commands and emits a one-cycle write
// strobe carrying the address and data.
//
// Frame: SYNC_BYTE, ADDR, DATA_BYTES data bytes (MSB first), and an optional
// XOR checksum byte. Frames that are broken, stalled or fail the checksum are
// counted and discarded.
//
// Build option: define UART_REG_CMD_CHECKSUM_EN to enable the checksum byte.
// The checksum is the XOR of the ADDR byte and all data bytes. Without the
// macro, a frame ends after its last data byte.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-high reset
//   rx_valid   in   one-cycle strobe; rx_data holds a received byte
//   rx_data    in   received byte
//   rx_break   in   BREAK indication, qualified by rx_valid
//   reg_wr_en  out  one-cycle register write strobe
//   reg_addr   out  write address; held between commits
//   reg_wdata  out  write data; held between commits
//   frame_err  out  one-cycle pulse when a frame is aborted
//   err_count  out  aborted-frame count, saturating at 255
//   busy       out  high whenever the decoder is not idle
module uart_reg_cmd #(
  parameter int         DATA_BYTES     = 4,
  parameter int         ADDR_BITS      = 8,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  input  logic                    rx_break,
  output logic                    reg_wr_en,
  output logic [ADDR_BITS-1:0]    reg_addr,
  output logic [8*DATA_BYTES-1:0] reg_wdata,
  output logic                    frame_err,
  output logic [7:0]              err_count,
  output logic                    busy
);

  localparam int DW = 8 * DATA_BYTES;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ADDR   = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_REG_CMD_CHECKSUM_EN
  localparam logic [2:0] ST_CSUM   = 3'd3;
`endif
  localparam logic [2:0] ST_COMMIT = 3'd4;

  localparam logic [2:0]    LAST_IDX = 3'(DATA_BYTES - 1);
  // The counter reaches TIMEOUT_CYCLES-1 on the edge that follows this value.
  localparam logic [TW-1:0] TMO_PRE  = TW'(TIMEOUT_CYCLES - 2);

  logic [2:0]           state_r;
  logic [2:0]           state_n_s;
  logic                 abort_s;
  logic                 timeout_s;
  logic                 byte_ok_s;
  logic [ADDR_BITS-1:0] addr_sh_r;
  logic [DW-1:0]        data_sh_r;
  logic [2:0]           idx_r;
  logic [TW-1:0]        tmo_cnt_r;
`ifdef UART_REG_CMD_CHECKSUM_EN
  logic [7:0]           csum_r;

  // Running XOR checksum over ADDR and data bytes.
  function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`endif

  // Shifts a new byte into the low end, so the first byte ends up in the MSBs.
  function automatic logic [DW-1:0] shift_in(input logic [DW-1:0] cur, input logic [7:0] b);
    logic [DW+7:0] tmp;
    tmp = {cur, b};
    return tmp[DW-1:0];
  endfunction

  // A byte arriving in the timeout cycle wins over the timeout.
  assign timeout_s = (tmo_cnt_r == TMO_PRE) && !rx_valid;
  assign byte_ok_s = rx_valid && !rx_break;

  // Next-state and abort decode.
  always_comb begin
    state_n_s = state_r;
    abort_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Junk and BREAK while idle are dropped without an error.
        if (byte_ok_s && (rx_data == SYNC_BYTE)) begin
          state_n_s = ST_ADDR;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (rx_valid) begin
          if (rx_break) begin
            abort_s = 1'b1;
          end else begin
            state_n_s = ST_DATA;
          end
        end else if (timeout_s) begin
          abort_s = 1'b1;
        end else begin
          state_n_s = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          if (rx_break) begin
            abort_s = 1'b1;
          end else if (idx_r == LAST_IDX) begin
`ifdef UART_REG_CMD_CHECKSUM_EN
            state_n_s = ST_CSUM;
`else
            state_n_s = ST_COMMIT;
`endif
          end else begin
            state_n_s = ST_DATA;
          end
        end else if (timeout_s) begin
          abort_s = 1'b1;
        end else begin
          state_n_s = ST_DATA;
        end
      end
`ifdef UART_REG_CMD_CHECKSUM_EN
      ST_CSUM: begin
        if (rx_valid) begin
          if (rx_break || (rx_data != csum_r)) begin
            abort_s = 1'b1;
          end else begin
            state_n_s = ST_COMMIT;
          end
        end else if (timeout_s) begin
          abort_s = 1'b1;
        end else begin
          state_n_s = ST_CSUM;
        end
      end
`endif
      ST_COMMIT: begin
        state_n_s = ST_IDLE;
      end
      default: begin
        state_n_s = ST_IDLE;
      end
    endcase
    if (abort_s) begin
      state_n_s = ST_IDLE;
    end else begin
      state_n_s = state_n_s;
    end
  end

  // FSM state, registered status outputs and error counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      busy      <= 1'b0;
      reg_wr_en <= 1'b0;
      frame_err <= 1'b0;
      err_count <= 8'd0;
    end else begin
      state_r   <= state_n_s;
      busy      <= (state_n_s != ST_IDLE);
      reg_wr_en <= (state_r == ST_COMMIT);
      frame_err <= abort_s;
      if (abort_s && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

  // Shadow capture of address, data, byte index and checksum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_sh_r <= '0;
      data_sh_r <= '0;
      idx_r     <= 3'd0;
`ifdef UART_REG_CMD_CHECKSUM_EN
      csum_r    <= 8'd0;
`endif
    end else begin
      if ((state_r == ST_ADDR) && byte_ok_s) begin
        addr_sh_r <= rx_data[ADDR_BITS-1:0];
        idx_r     <= 3'd0;
`ifdef UART_REG_CMD_CHECKSUM_EN
        csum_r    <= rx_data;
`endif
      end else if ((state_r == ST_DATA) && byte_ok_s) begin
        data_sh_r <= shift_in(data_sh_r, rx_data);
        idx_r     <= idx_r + 3'd1;
`ifdef UART_REG_CMD_CHECKSUM_EN
        csum_r    <= csum_next(csum_r, rx_data);
`endif
      end
    end
  end

  // Output address/data change only on commit and are held otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_addr  <= '0;
      reg_wdata <= '0;
    end else if (state_r == ST_COMMIT) begin
      reg_addr  <= addr_sh_r;
      reg_wdata <= data_sh_r;
    end
  end

  // Inter-byte timeout counter: cleared by any byte and while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt_r <= '0;
    end else if ((state_r == ST_IDLE) || rx_valid) begin
      tmo_cnt_r <= '0;
    end else begin
      tmo_cnt_r <= tmo_cnt_r + TW'(1);
    end
  end

endmodule

// File: tb/tb_uart_reg_cmd.sv
// Self-checking bench for uart_reg_cmd (TIMEOUT_CYCLES = 100).
// Expected writes are queued when a frame is driven and popped when the DUT
// strobes reg_wr_en. Follows UART_REG_CMD_CHECKSUM_EN if it is defined.
module tb_uart_reg_cmd;
  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_break = 1'b0;
  logic        reg_wr_en;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        frame_err;
  logic [7:0]  err_count;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  int err_pulses = 0;
  int err_model = 0;
  logic [39:0] wr_q[$];

  uart_reg_cmd #(
    .DATA_BYTES(4), .ADDR_BITS(8), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_break(rx_break), .reg_wr_en(reg_wr_en), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .frame_err(frame_err), .err_count(err_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write scoreboard and error-pulse counter.
  logic prev_wr = 1'b0;
  always @(negedge clk) begin
    if (reg_wr_en) begin
      chk("wr_width", {63'd0, prev_wr}, 64'd0);
      if (wr_q.size() == 0) begin
        chk("unexpected_wr", 64'd1, 64'd0);
      end else begin
        logic [39:0] e;
        e = wr_q.pop_front();
        chk("wr_addr", {56'd0, reg_addr}, {56'd0, e[39:32]});
        chk("wr_data", {32'd0, reg_wdata}, {32'd0, e[31:0]});
      end
    end
    if (frame_err) err_pulses++;
    prev_wr = reg_wr_en;
  end

  task automatic send_byte(input logic [7:0] b, input logic brk);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    rx_break = brk;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_break = 1'b0;
    rx_data  = 8'h00;
  endtask

  function automatic logic [7:0] csum_of(input logic [7:0] a, input logic [31:0] d);
    return a ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
  endfunction

  // Drives a complete frame; corrupt sends an inverted checksum.
  task automatic send_frame(input logic [7:0] a, input logic [31:0] d, input logic corrupt);
    logic [7:0] cs;
    cs = csum_of(a, d);
    if (corrupt) cs = ~cs;
    if (!corrupt) wr_q.push_back({a, d});
    send_byte(8'hA5, 1'b0);
    send_byte(a, 1'b0);
    for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8], 1'b0);
`ifdef UART_REG_CMD_CHECKSUM_EN
    send_byte(cs, 1'b0);
`endif
    // Last byte was sampled on the edge just before this negedge.
    if (corrupt) begin
      err_model = (err_model < 255) ? err_model + 1 : 255;
      chk("csum_err", {63'd0, frame_err}, 64'd1);
      @(negedge clk);
      chk("csum_err_end", {63'd0, frame_err}, 64'd0);
    end else begin
      chk("lat_n1", {63'd0, reg_wr_en}, 64'd0);
      @(negedge clk);
      chk("lat_n2", {63'd0, reg_wr_en}, 64'd1);
      chk("no_err", {63'd0, frame_err}, 64'd0);
      @(negedge clk);
      chk("lat_n3", {63'd0, reg_wr_en}, 64'd0);
    end
    chk("busy_after", {63'd0, busy}, 64'd0);
    chk("err_count", {56'd0, err_count}, err_model);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_wr", {63'd0, reg_wr_en}, 64'd0);
    chk("rst_addr", {56'd0, reg_addr}, 64'd0);
    chk("rst_data", {32'd0, reg_wdata}, 64'd0);
    chk("rst_ferr", {63'd0, frame_err}, 64'd0);
    chk("rst_cnt", {56'd0, err_count}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    reset = 1'b0;

    // Reference frame (checksum of 10 DE AD BE EF is 8'h32).
    send_frame(8'h10, 32'hDEADBEEF, 1'b0);

`ifdef UART_REG_CMD_CHECKSUM_EN
    // Bad checksum: no write, outputs held, then a good frame.
    send_frame(8'h10, 32'hDEADBEEF, 1'b1);
    chk("hold_addr", {56'd0, reg_addr}, 64'h10);
    chk("hold_data", {32'd0, reg_wdata}, 64'hDEADBEEF);
    send_frame(8'h22, 32'h01234567, 1'b0);
`endif

    // Junk before sync is silently dropped.
    send_byte(8'h00, 1'b0); chk("junk_busy0", {63'd0, busy}, 64'd0);
    send_byte(8'hFF, 1'b0); chk("junk_busy1", {63'd0, busy}, 64'd0);
    send_byte(8'h5A, 1'b0); chk("junk_busy2", {63'd0, busy}, 64'd0);
    chk("junk_cnt", {56'd0, err_count}, err_model);
    send_frame(8'h33, 32'hCAFEF00D, 1'b0);

    // BREAK mid-frame; the breaking byte is A5 but must not restart a frame.
    send_byte(8'hA5, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'hDE, 1'b0);
    chk("busy_mid", {63'd0, busy}, 64'd1);
    send_byte(8'hA5, 1'b1);
    err_model++;
    chk("brk_err", {63'd0, frame_err}, 64'd1);
    chk("brk_busy", {63'd0, busy}, 64'd0);
    chk("brk_cnt", {56'd0, err_count}, err_model);
    @(negedge clk);
    chk("brk_err_end", {63'd0, frame_err}, 64'd0);
    chk("brk_hold", {32'd0, reg_wdata}, 64'hCAFEF00D);

    // Timeout: abort exactly TMO-1 cycles after the last byte.
    send_byte(8'hA5, 1'b0);
    send_byte(8'h10, 1'b0);
    for (int i = 2; i <= TMO; i++) begin
      @(negedge clk);
      chk($sformatf("tmo_c%0d", i), {63'd0, frame_err}, (i == TMO) ? 64'd1 : 64'd0);
    end
    err_model++;
    chk("tmo_cnt", {56'd0, err_count}, err_model);
    chk("tmo_busy", {63'd0, busy}, 64'd0);

    // A byte in the timeout cycle wins; frame then completes.
    wr_q.push_back({8'h10, 32'hDEADBEEF});
    send_byte(8'hA5, 1'b0);
    send_byte(8'h10, 1'b0);
    repeat (TMO - 3) @(negedge clk);
    send_byte(8'hDE, 1'b0);
    chk("rescue_err", {63'd0, frame_err}, 64'd0);
    chk("rescue_busy", {63'd0, busy}, 64'd1);
    send_byte(8'hAD, 1'b0);
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b0);
`ifdef UART_REG_CMD_CHECKSUM_EN
    send_byte(csum_of(8'h10, 32'hDEADBEEF), 1'b0);
`endif
    repeat (3) @(negedge clk);
    chk("rescue_cnt", {56'd0, err_count}, err_model);

    // SYNC value as payload is ordinary data.
    send_frame(8'hA5, 32'hA5A5A5A5, 1'b0);

    // Reset mid-frame: outputs clear at once, no pulses.
    send_byte(8'hA5, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'hDE, 1'b0);
    reset = 1'b1;
    #1;
    chk("mrst_addr", {56'd0, reg_addr}, 64'd0);
    chk("mrst_data", {32'd0, reg_wdata}, 64'd0);
    chk("mrst_cnt", {56'd0, err_count}, 64'd0);
    chk("mrst_busy", {63'd0, busy}, 64'd0);
    chk("mrst_wr", {63'd0, reg_wr_en}, 64'd0);
    chk("mrst_ferr", {63'd0, frame_err}, 64'd0);
    p0 = err_pulses;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    err_model = 0;
    repeat (3) @(negedge clk);
    chk("mrst_nopulse", p0, err_pulses);
    chk("mrst_idle", {63'd0, busy}, 64'd0);

    // Saturation: 256 aborts leave err_count at 255, pulses continue.
    p0 = err_pulses;
    for (int k = 0; k < 256; k++) begin
      send_byte(8'hA5, 1'b0);
      send_byte(8'h00, 1'b1);
    end
    @(negedge clk);
    chk("sat_cnt", {56'd0, err_count}, 64'd255);
    chk("sat_pulses", err_pulses - p0, 64'd256);

    // Still decodes after saturation.
    err_model = 255;
    send_frame(8'h7E, 32'h0BADF00D, 1'b0);

    repeat (4) @(negedge clk);
    chk("wr_q_empty", wr_q.size(), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
